req_sync_arbiter: RTL and testbench

- Collects four-phase level requests from NUM_REQ asynchronous source domains and grants them one at a time to a single local consumer in the i_clk domain.
- Synchronizes each request with the team's bits_sync (BUS_WIDTH=NUM_REQ, NUM_RETIME passed through).
- Arbitrates round-robin and returns a level acknowledge per channel; each source synchronizes its acknowledge back into its own domain.

---
 rtl/req_sync_arbiter.sv | 139 +++++++++++++
 tb/tb_req_sync_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_sync_arbiter.sv
// Round-robin arbiter for four-phase level requests arriving from asynchronous
// source domains; each channel gets a registered level acknowledge back.

module bits_sync #(
    parameter int BUS_WIDTH  = 1,
    parameter int NUM_RETIME = 2
) (
    input  logic                 i_clk,
    input  logic [BUS_WIDTH-1:0] i_data,
    output logic [BUS_WIDTH-1:0] o_data
);
    logic [BUS_WIDTH-1:0] sync_q [NUM_RETIME];

    always_ff @(posedge i_clk) begin
        sync_q[0] <= i_data;
        for (int s = 1; s < NUM_RETIME; s++) begin
            sync_q[s] <= sync_q[s-1];
        end
    end

    assign o_data = sync_q[NUM_RETIME-1];
endmodule

module req_sync_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  NUM_RETIME = 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req_a,
    output logic [NUM_REQ-1:0] o_ack,
    output logic               o_gnt_valid,
    output logic [ID_W-1:0]    o_gnt_id,
    input  logic               i_gnt_ready
);
    typedef enum logic [1:0] {IDLE, PEND, ACKED} ch_state_e;

    ch_state_e          st     [NUM_REQ];
    ch_state_e          st_nxt [NUM_REQ];
    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] cand;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W:0]      idx;
    logic               sel_found;
    logic               accept;
    logic               load;

    bits_sync #(
        .BUS_WIDTH  (NUM_REQ),
        .NUM_RETIME (NUM_RETIME)
    ) u_req_sync (
        .i_clk  (i_clk),
        .i_data (i_req_a),
        .o_data (req_s)
    );

    assign accept = o_gnt_valid & i_gnt_ready;
    assign load   = ~o_gnt_valid | i_gnt_ready;

    // The channel being accepted is still PEND this cycle and must not be re-picked.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand[i] = (st[i] == PEND) && !(accept && (o_gnt_id == ID_W'(i)));
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (!sel_found && cand[idx[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = idx[ID_W-1:0];
            end
        end
    end

    // A channel sitting in the grant register is committed: withdrawal no longer applies.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            st_nxt[i] = st[i];
            case (st[i])
                IDLE: begin
                    if (req_s[i] && !o_ack[i]) st_nxt[i] = PEND;
                end
                PEND: begin
                    if (o_gnt_valid && (o_gnt_id == ID_W'(i))) begin
                        if (i_gnt_ready) st_nxt[i] = ACKED;
                    end else if (!(load && sel_found && (sel_id == ID_W'(i))) && !req_s[i]) begin
                        st_nxt[i] = IDLE;
                    end
                end
                ACKED: begin
                    if (!req_s[i]) st_nxt[i] = IDLE;
                end
                default: st_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) st[i] <= IDLE;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) st[i] <= st_nxt[i];
        end
    end

    // Acks leave the domain, so each is a dedicated flop rather than a state decode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ack <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) o_ack[i] <= (st_nxt[i] == ACKED);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_gnt_valid <= 1'b0;
            o_gnt_id    <= '0;
            ptr         <= '0;
        end else begin
            if (load) begin
                o_gnt_valid <= sel_found;
                if (sel_found) o_gnt_id <= sel_id;
            end
            if (accept) begin
                ptr <= (o_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : o_gnt_id + ID_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_req_sync_arbiter.sv
// Bench for req_sync_arbiter: directed scenarios on 4- and 3-channel instances
// plus randomized four-phase traffic checked against a behavioural model.

module tb_req_sync_arbiter;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req4  = '0;
    logic [3:0] ack4;
    logic       vld4;
    logic       rdy4  = 1'b0;
    logic [1:0] id4;
    logic [2:0] req3  = '0;
    logic [2:0] ack3;
    logic       vld3;
    logic       rdy3  = 1'b0;
    logic [1:0] id3;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the 4-channel instance: request history, pending/acked sets, grant, pointer
    bit [3:0] m_hist [2];
    bit [3:0] m_pend;
    bit [3:0] m_ack;
    bit       m_vld;
    int       m_id;
    int       m_ptr;
    int       got3 [$];

    req_sync_arbiter #(.NUM_REQ(4), .NUM_RETIME(2)) d4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_a(req4), .o_ack(ack4),
        .o_gnt_valid(vld4), .o_gnt_id(id4), .i_gnt_ready(rdy4));

    req_sync_arbiter #(.NUM_REQ(3), .NUM_RETIME(2)) d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_a(req3), .o_ack(ack3),
        .o_gnt_valid(vld3), .o_gnt_id(id3), .i_gnt_ready(rdy3));

    initial forever #5 clk = ~clk;

    task automatic tick();
        bit [3:0] rs, np, na, h0;
        bit       acc, ld, found, nv;
        int       sel, nid, nptr, c;
        rs    = m_hist[1];
        h0    = req4;
        acc   = m_vld && rdy4;
        ld    = !m_vld || acc;
        found = 0;
        sel   = 0;
        for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (!found && m_pend[c] && !(acc && c == m_id)) begin
                found = 1;
                sel   = c;
            end
        end
        np = m_pend;
        na = m_ack;
        for (int j = 0; j < 4; j++) begin
            if (m_ack[j]) begin
                if (!rs[j]) na[j] = 0;
            end else if (m_pend[j]) begin
                if (m_vld && m_id == j) begin
                    if (acc) begin
                        np[j] = 0;
                        na[j] = 1;
                    end
                end else if (!(ld && found && sel == j) && !rs[j]) begin
                    np[j] = 0;
                end
            end else if (rs[j]) begin
                np[j] = 1;
            end
        end
        nv   = m_vld;
        nid  = m_id;
        nptr = acc ? (m_id + 1) % 4 : m_ptr;
        if (ld) begin
            nv = found;
            if (found) nid = sel;
        end
        @(posedge clk);
        m_hist[1] = m_hist[0];
        m_hist[0] = h0;
        #1;
        if (!rst_n) begin
            m_pend = '0; m_ack = '0; m_vld = 0; m_id = 0; m_ptr = 0;
        end else begin
            m_pend = np; m_ack = na; m_vld = nv; m_id = nid; m_ptr = nptr;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req4 = '0; req3 = '0; rdy4 = 1'b0; rdy3 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ack4 !== 4'b0 || vld4 !== 1'b0 || id4 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_d4 ack=%b vld=%b id=%0d, want 0/0/0", ack4, vld4, id4);
        end
        n_tests++;
        if (ack3 !== 3'b0 || vld3 !== 1'b0 || id3 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_d3 ack=%b vld=%b id=%0d, want 0/0/0", ack3, vld3, id3);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        rdy4 = 1'b1;
        req4 = 4'b0100;
        repeat (3) tick();
        n_tests++;
        if (vld4 !== 1'b0) begin
            n_fail++; $display("FAIL single_early_vld got %b want 0", vld4);
        end
        tick();
        n_tests++;
        if (vld4 !== 1'b1 || id4 !== 2'd2 || ack4 !== 4'b0) begin
            n_fail++; $display("FAIL single_grant vld=%b id=%0d ack=%b want 1/2/0000", vld4, id4, ack4);
        end
        tick();
        n_tests++;
        if (ack4 !== 4'b0100 || vld4 !== 1'b0) begin
            n_fail++; $display("FAIL single_ack ack=%b vld=%b want 0100/0", ack4, vld4);
        end
        req4 = 4'b0;
        repeat (2) tick();
        n_tests++;
        if (ack4 !== 4'b0100) begin
            n_fail++; $display("FAIL single_ack_hold got %b want 0100", ack4);
        end
        tick();
        n_tests++;
        if (ack4 !== 4'b0) begin
            n_fail++; $display("FAIL single_ack_clear got %b want 0000", ack4);
        end
    endtask

    task automatic test_fairness();
        int order [$];
        do_reset();
        rdy4 = 1'b1;
        req4 = 4'hF;
        for (int cyc = 0; cyc < 300 && order.size() < 12; cyc++) begin
            if (vld4 && rdy4) order.push_back(int'(id4));
            tick();
            for (int c = 0; c < 4; c++) begin
                if (ack4[c] && req4[c]) req4[c] = 1'b0;
                else if (!ack4[c] && !req4[c]) req4[c] = 1'b1;
            end
        end
        n_tests++;
        if (order.size() != 12) begin
            n_fail++; $display("FAIL fair_count got %0d grants want 12", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            n_tests++;
            if (order[k] != k % 4) begin
                n_fail++; $display("FAIL fair_order[%0d] got %0d want %0d", k, order[k], k % 4);
            end
        end
        req4 = '0;
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        req4 = 4'b0010;
        for (int cyc = 0; cyc < 10 && !vld4; cyc++) tick();
        n_tests++;
        if (vld4 !== 1'b1 || id4 !== 2'd1) begin
            n_fail++; $display("FAIL bp_first vld=%b id=%0d want 1/1", vld4, id4);
        end
        req4[3] = 1'b1;
        ok = 1;
        repeat (10) begin
            tick();
            if (vld4 !== 1'b1 || id4 !== 2'd1 || ack4 !== 4'b0) ok = 0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL bp_hold vld=%b id=%0d ack=%b want 1/1/0000", vld4, id4, ack4);
        end
        rdy4 = 1'b1;
        tick();
        n_tests++;
        if (ack4 !== 4'b0010 || vld4 !== 1'b1 || id4 !== 2'd3) begin
            n_fail++; $display("FAIL bp_release ack=%b vld=%b id=%0d want 0010/1/3", ack4, vld4, id4);
        end
    endtask

    task automatic test_withdrawal();
        bit bad;
        do_reset();
        req4 = 4'b0100;
        for (int cyc = 0; cyc < 10 && !vld4; cyc++) tick();
        n_tests++;
        if (vld4 !== 1'b1 || id4 !== 2'd2) begin
            n_fail++; $display("FAIL wd_busy vld=%b id=%0d want 1/2", vld4, id4);
        end
        req4[0] = 1'b1;
        tick();
        req4[0] = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (ack4[0] || (vld4 && id4 == 2'd0)) bad = 1;
        end
        rdy4 = 1'b1;
        tick();
        n_tests++;
        if (ack4 !== 4'b0100) begin
            n_fail++; $display("FAIL wd_accept2 ack=%b want 0100", ack4);
        end
        repeat (6) begin
            tick();
            if (ack4[0] || (vld4 && id4 == 2'd0)) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL wd_no_grant0 channel 0 was granted or acked, want never");
        end
    endtask

    task automatic run3(input int n);
        int cnt;
        cnt = 0;
        for (int cyc = 0; cyc < 40 && cnt < n; cyc++) begin
            if (vld3 && rdy3) begin
                got3.push_back(int'(id3));
                cnt++;
            end
            tick();
            for (int c = 0; c < 3; c++) if (ack3[c]) req3[c] = 1'b0;
        end
        repeat (8) begin
            tick();
            for (int c = 0; c < 3; c++) if (ack3[c]) req3[c] = 1'b0;
        end
    endtask

    task automatic test_wrap3();
        int exp3 [5] = '{1, 0, 1, 2, 0};
        do_reset();
        got3.delete();
        rdy3 = 1'b1;
        req3 = 3'b010;
        run3(1);
        req3 = 3'b011;
        run3(2);
        req3 = 3'b101;
        run3(2);
        n_tests++;
        if (got3.size() != 5) begin
            n_fail++; $display("FAIL wrap3_count got %0d grants want 5", got3.size());
        end
        for (int k = 0; k < 5 && k < got3.size(); k++) begin
            n_tests++;
            if (got3[k] != exp3[k]) begin
                n_fail++; $display("FAIL wrap3_order[%0d] got %0d want %0d", k, got3[k], exp3[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        req4 = 4'b1010;
        for (int cyc = 0; cyc < 10 && !vld4; cyc++) tick();
        rdy4 = 1'b1;
        tick();
        rdy4 = 1'b0;
        n_tests++;
        if (vld4 !== 1'b1 || id4 !== 2'd3 || ack4 !== 4'b0010) begin
            n_fail++; $display("FAIL rmid_setup vld=%b id=%0d ack=%b want 1/3/0010", vld4, id4, ack4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (vld4 !== 1'b0 || ack4 !== 4'b0) begin
            n_fail++; $display("FAIL rmid_async vld=%b ack=%b want 0/0000", vld4, ack4);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 4 && !seen; cyc++) begin
            tick();
            if (vld4 && id4 == 2'd1) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL rmid_regrant vld=%b id=%0d want 1/1 within 4 edges", vld4, id4);
        end
        req4 = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (req4[c] && m_ack[c]) begin
                    if ($urandom_range(2) == 0) req4[c] = 1'b0;
                end else if (!req4[c] && !m_ack[c]) begin
                    if ($urandom_range(3) == 0) req4[c] = 1'b1;
                end else if (req4[c] && !m_ack[c]) begin
                    if ($urandom_range(19) == 0) req4[c] = 1'b0;
                end
            end
            rdy4 = ($urandom_range(2) != 0);
            tick();
            n_tests++;
            if (ack4 !== m_ack || vld4 !== m_vld || (m_vld && id4 !== 2'(m_id))) begin
                n_fail++;
                $display("FAIL random cyc %0d ack=%b/%b vld=%b/%b id=%0d/%0d (got/want)",
                         cyc, ack4, m_ack, vld4, m_vld, id4, m_id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_withdrawal();
        test_wrap3();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
